// File: rtl/writeback_pkg.sv
// Shared types for the writeback stage: boolean type, control bus encoding,
// FSM states and the canned control words the control unit issues.
package boolPkg;
  typedef enum logic {F = 1'b0, T = 1'b1} bool;
endpackage

package writebackGroup;
  import boolPkg::*;

  typedef enum logic [1:0] {ALU = 2'd0, MEMORY = 2'd1, NEXTPC = 2'd2} resultMux;
  typedef enum logic [1:0] {WORD = 2'd0, HALF = 2'd1, BYTE = 2'd2} loadSize;

  typedef struct packed {
    bool      regWriteEn;
    resultMux resultSel;
    loadSize  size;
    bool      signExtend;
  } controlBus;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_MEM = 2'd1, WRITE = 2'd2, FAULT = 2'd3} wbState;

  localparam controlBus NO_OP       = '{regWriteEn: F, resultSel: ALU,    size: WORD, signExtend: F};
  localparam controlBus ALU_RESULT  = '{regWriteEn: T, resultSel: ALU,    size: WORD, signExtend: F};
  localparam controlBus LINK        = '{regWriteEn: T, resultSel: NEXTPC, size: WORD, signExtend: F};
  localparam controlBus LOAD_WORD   = '{regWriteEn: T, resultSel: MEMORY, size: WORD, signExtend: F};
  localparam controlBus LOAD_HALF_S = '{regWriteEn: T, resultSel: MEMORY, size: HALF, signExtend: T};
  localparam controlBus LOAD_HALF_U = '{regWriteEn: T, resultSel: MEMORY, size: HALF, signExtend: F};
  localparam controlBus LOAD_BYTE_S = '{regWriteEn: T, resultSel: MEMORY, size: BYTE, signExtend: T};
  localparam controlBus LOAD_BYTE_U = '{regWriteEn: T, resultSel: MEMORY, size: BYTE, signExtend: F};

  function automatic logic isAligned(input loadSize size, input logic [1:0] addr);
    case (size)
      WORD:    return addr == 2'b00;
      HALF:    return !addr[0];
      default: return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/writeback_load_align.sv
// Little-endian load lane extraction with sign or zero extension.
// Purely combinational; misaligned addresses are filtered upstream.
module loadAlign
  import boolPkg::*;
  import writebackGroup::*;
(
  input  logic [31:0] memReadData,
  input  logic [1:0]  addr,
  input  loadSize     size,
  input  bool         signExtend,
  output logic [31:0] alignedData
);
  logic [7:0]  byteLane;
  logic [15:0] halfLane;
  logic        fill;

  always_comb begin
    byteLane    = memReadData[{addr, 3'b000} +: 8];
    halfLane    = memReadData[{addr[1], 4'b0000} +: 16];
    fill        = 1'b0;
    alignedData = memReadData;
    case (size)
      BYTE: begin
        fill        = (signExtend == T) && byteLane[7];
        alignedData = {{24{fill}}, byteLane};
      end
      HALF: begin
        fill        = (signExtend == T) && halfLane[15];
        alignedData = {{16{fill}}, halfLane};
      end
      default: alignedData = memReadData;
    endcase
  end
endmodule

// File: rtl/writeback.sv
// Final datapath stage: selects ALU / load / link result and issues one
// register-file write per accepted instruction; all outputs are registered.
module writeback
  import boolPkg::*;
  import writebackGroup::*;
(
  input  logic        clk,
  input  logic        reset,
  input  controlBus   writebackControl,
  input  logic        start,
  input  logic [31:0] aluResult,
  input  logic [31:0] nextPC,
  input  logic [4:0]  destIndex,
  input  logic [31:0] memReadData,
  input  logic        memReadValid,
  output logic        regFileWriteEn,
  output logic [4:0]  regFileWriteIndex,
  output logic [31:0] regFileWriteData,
  output logic        busy,
  output logic        done,
  output logic        misalignedFault
);
  wbState      state_q;
  bool         wrEn_q;
  loadSize     size_q;
  bool         sext_q;
  logic [1:0]  addr_q;
  logic [4:0]  dest_q;
  logic        wen_q;
  logic [4:0]  idx_q;
  logic [31:0] data_q;
  logic        busy_q;
  logic        done_q;
  logic        fault_q;
  logic [31:0] alignedData;

  loadAlign u_loadAlign (
    .memReadData (memReadData),
    .addr        (addr_q),
    .size        (size_q),
    .signExtend  (sext_q),
    .alignedData (alignedData)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wrEn_q  <= F;
      size_q  <= WORD;
      sext_q  <= F;
      addr_q  <= 2'b00;
      dest_q  <= 5'd0;
      wen_q   <= 1'b0;
      idx_q   <= 5'd0;
      data_q  <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wen_q   <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          wrEn_q <= writebackControl.regWriteEn;
          size_q <= writebackControl.size;
          sext_q <= writebackControl.signExtend;
          addr_q <= aluResult[1:0];
          dest_q <= destIndex;
          busy_q <= 1'b1;
          if (writebackControl.resultSel == MEMORY) begin
            if (isAligned(writebackControl.size, aluResult[1:0])) begin
              state_q <= WAIT_MEM;
            end else begin
              state_q <= FAULT;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end
          end else begin
            state_q <= WRITE;
            done_q  <= 1'b1;
            wen_q   <= (writebackControl.regWriteEn == T) && (destIndex != 5'd0);
            idx_q   <= destIndex;
            data_q  <= (writebackControl.resultSel == NEXTPC) ? nextPC : aluResult;
          end
        end
        WAIT_MEM: if (memReadValid) begin
          state_q <= WRITE;
          done_q  <= 1'b1;
          wen_q   <= (wrEn_q == T) && (dest_q != 5'd0);
          idx_q   <= dest_q;
          data_q  <= alignedData;
        end
        default: begin
          // WRITE and FAULT are single-cycle; outputs were set on entry
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign regFileWriteEn    = wen_q;
  assign regFileWriteIndex = idx_q;
  assign regFileWriteData  = data_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign misalignedFault   = fault_q;
endmodule

// File: tb/tb_writeback.sv
// Randomized scoreboard bench for writeback: a driver issues instructions and
// queues expected completions; a monitor pops and compares on every done pulse.
module tb_writeback;
  import boolPkg::*;
  import writebackGroup::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  controlBus   writebackControl;
  logic        start;
  logic [31:0] aluResult, nextPC, memReadData;
  logic [4:0]  destIndex;
  logic        memReadValid;
  logic        regFileWriteEn, busy, done, misalignedFault;
  logic [4:0]  regFileWriteIndex;
  logic [31:0] regFileWriteData;

  logic [31:0] la_data, la_out;
  logic [1:0]  la_addr;
  loadSize     la_size;
  bool         la_sx;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    bit          fault;
    bit          wen;
    logic [4:0]  idx;
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t expq[$];

  writeback dut (
    .clk               (clk),
    .reset             (reset),
    .writebackControl  (writebackControl),
    .start             (start),
    .aluResult         (aluResult),
    .nextPC            (nextPC),
    .destIndex         (destIndex),
    .memReadData       (memReadData),
    .memReadValid      (memReadValid),
    .regFileWriteEn    (regFileWriteEn),
    .regFileWriteIndex (regFileWriteIndex),
    .regFileWriteData  (regFileWriteData),
    .busy              (busy),
    .done              (done),
    .misalignedFault   (misalignedFault)
  );

  loadAlign u_la (
    .memReadData (la_data),
    .addr        (la_addr),
    .size        (la_size),
    .signExtend  (la_sx),
    .alignedData (la_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference lane extraction from the little-endian rules, using shifts/masks.
  function automatic logic [31:0] extract(input logic [31:0] mem, input int a,
                                          input loadSize sz, input bit sx);
    logic [31:0] v;
    if (sz == BYTE) begin
      v = (mem >> (8 * a)) & 32'h0000_00FF;
      if (sx && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == HALF) begin
      v = (mem >> (16 * (a / 2))) & 32'h0000_FFFF;
      if (sx && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = mem;
    end
    return v;
  endfunction

  task automatic model(input controlBus c, input logic [31:0] alu, input logic [31:0] npc,
                       input logic [4:0] dest, input logic [31:0] mem, input int delay,
                       output exp_t e);
    int a;
    a       = int'(alu[1:0]);
    e.fault = 1'b0;
    e.idx   = dest;
    e.wen   = (c.regWriteEn == T) && (dest != 5'd0);
    e.lat   = 1;
    e.data  = alu;
    if (c.resultSel == NEXTPC) begin
      e.data = npc;
    end else if (c.resultSel == MEMORY) begin
      if ((c.size == WORD && a % 4 != 0) || (c.size == HALF && a % 2 != 0)) begin
        e.fault = 1'b1;
        e.wen   = 1'b0;
      end else begin
        e.lat  = delay + 1;
        e.data = extract(mem, a, c.size, c.signExtend == T);
      end
    end
  endtask

  function automatic controlBus randCtrl();
    controlBus c;
    c.regWriteEn = bool'($urandom_range(0, 1) != 0);
    c.resultSel  = resultMux'(2'($urandom_range(0, 2)));
    c.size       = loadSize'(2'($urandom_range(0, 2)));
    c.signExtend = bool'($urandom_range(0, 1) != 0);
    return c;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after completion.
  task automatic issue(input controlBus c, input logic [31:0] alu, input logic [31:0] npc,
                       input logic [4:0] dest, input logic [31:0] mem, input int delay,
                       input bit earlyPulse, input bit restart);
    exp_t e;
    bit   seen;
    model(c, alu, npc, dest, mem, delay, e);
    expq.push_back(e);
    writebackControl = c;
    aluResult        = alu;
    nextPC           = npc;
    destIndex        = dest;
    memReadData      = earlyPulse ? $urandom : mem;
    memReadValid     = earlyPulse;
    start            = 1'b1;
    seen             = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (done) begin
        chk("latency", cyc, e.lat);
        chk("busy_at_done", {31'd0, busy}, 32'd1);
        seen         = 1'b1;
        start        = 1'b0;
        memReadValid = 1'b0;
        break;
      end
      start            = restart && (cyc == 1);
      writebackControl = randCtrl();
      aluResult        = $urandom;
      nextPC           = $urandom;
      destIndex        = 5'($urandom);
      memReadValid     = (cyc == delay);
      memReadData      = (cyc == delay) ? mem : $urandom;
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: got no done within 60 cycles, required latency %0d", e.lat);
      if (expq.size() > 0) void'(expq.pop_back());
      start        = 1'b0;
      memReadValid = 1'b0;
    end
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  // Monitor: pops the scoreboard on each done pulse, flags any stray write.
  always @(negedge clk) begin
    if (!reset) begin
      chk("write_only_with_done", {31'd0, regFileWriteEn & ~done}, 32'd0);
      if (done) begin
        if (expq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: got done with empty scoreboard, required none");
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("misalignedFault", {31'd0, misalignedFault}, {31'd0, e.fault});
          chk("regFileWriteEn", {31'd0, regFileWriteEn}, {31'd0, e.wen});
          if (e.wen) begin
            chk("regFileWriteIndex", {27'd0, regFileWriteIndex}, {27'd0, e.idx});
            chk("regFileWriteData", regFileWriteData, e.data);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by time limit, required completion");
    $fatal(1);
  end

  initial begin
    controlBus c;
    start            = 1'b0;
    memReadValid     = 1'b0;
    writebackControl = NO_OP;
    aluResult        = 32'd0;
    nextPC           = 32'd0;
    destIndex        = 5'd0;
    memReadData      = 32'd0;

    repeat (2) @(negedge clk);
    chk("reset_wen", {31'd0, regFileWriteEn}, 32'd0);
    chk("reset_idx", {27'd0, regFileWriteIndex}, 32'd0);
    chk("reset_data", regFileWriteData, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_fault", {31'd0, misalignedFault}, 32'd0);

    for (int i = 0; i < 48; i++) begin
      la_data = $urandom;
      la_addr = 2'($urandom);
      la_size = loadSize'(2'($urandom_range(0, 2)));
      la_sx   = bool'($urandom_range(0, 1) != 0);
      if (i < 4) la_data = 32'h8080_8080;
      #1;
      chk("loadAlign", la_out, extract(la_data, int'(la_addr), la_size, la_sx == T));
    end

    reset = 1'b0;
    @(negedge clk);

    issue(ALU_RESULT, 32'h1234_5678, 32'h0, 5'd3, 32'h0, 1, 1'b0, 1'b0);
    issue(LOAD_BYTE_S, 32'h0000_1002, 32'h0, 5'd7, 32'h0080_0000, 3, 1'b0, 1'b0);
    issue(LOAD_BYTE_U, 32'h0000_1002, 32'h0, 5'd7, 32'h0080_0000, 3, 1'b0, 1'b0);
    issue(LOAD_HALF_U, 32'hABCD_0002, 32'h0, 5'd9, 32'hBEEF_1234, 2, 1'b0, 1'b0);
    issue(LOAD_HALF_S, 32'hABCD_0002, 32'h0, 5'd9, 32'hBEEF_1234, 1, 1'b0, 1'b0);
    issue(LOAD_WORD, 32'h0000_0001, 32'h0, 5'd5, 32'hDEAD_BEEF, 2, 1'b0, 1'b0);
    issue(LINK, 32'h0, 32'h0000_0100, 5'd0, 32'h0, 1, 1'b0, 1'b0);
    issue(LINK, 32'h0, 32'h0000_0100, 5'd31, 32'h0, 1, 1'b0, 1'b0);
    issue(LOAD_WORD, 32'h0000_0040, 32'h0, 5'd12, 32'hCAFE_F00D, 4, 1'b0, 1'b1);
    issue(LOAD_BYTE_U, 32'h0000_0003, 32'h0, 5'd4, 32'h5A00_0000, 3, 1'b1, 1'b0);
    issue(NO_OP, 32'h5555_5555, 32'h0, 5'd8, 32'h0, 1, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      c = randCtrl();
      issue(c, $urandom, $urandom, 5'($urandom), $urandom, $urandom_range(1, 5),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    // Abort a load mid-wait: outputs clear at once and the late response is dropped.
    writebackControl = LOAD_WORD;
    aluResult        = 32'h0000_0100;
    destIndex        = 5'd6;
    start            = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("busy_in_wait_mem", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_wen", {31'd0, regFileWriteEn}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_fault", {31'd0, misalignedFault}, 32'd0);
    chk("abort_idx", {27'd0, regFileWriteIndex}, 32'd0);
    chk("abort_data", regFileWriteData, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    memReadData  = 32'h1111_2222;
    memReadValid = 1'b1;
    @(negedge clk);
    memReadValid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_done", {31'd0, done}, 32'd0);
      chk("post_abort_busy", {31'd0, busy}, 32'd0);
    end

    chk("scoreboard_drained", expq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
